// File: rtl/raster_pkg.sv
// Shared types, constants and helpers for the raster quad sequencer.
// Optional perf counters are enabled by defining QUAD_SEQ_PERF_CNT_EN.
package raster_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic [SIGFIG-1:0]        word_t;
  typedef logic signed [SIGFIG-1:0] sword_t;
  typedef logic signed [SIGFIG:0]   ext_t;
  typedef word_t [AXIS-1:0]         vert_t;
  typedef vert_t [VERTS-1:0]        tri_t;
  typedef word_t [COLORS-1:0]       color_t;
  typedef word_t [1:0]              pt_t;
  typedef pt_t [1:0]                bbox_t;
  typedef word_t [3:0]              lane_t;
  typedef lane_t [1:0]              quad_t;
  typedef logic [4:0]               step_t;

  typedef enum logic {IDLE, WALK} seq_state_t;

  function automatic step_t subsample_step(input logic [3:0] oh);
    step_t k;
    k = step_t'(RADIX);
    unique case (1'b1)
      oh[3]:   k = step_t'(RADIX);
      oh[2]:   k = step_t'(RADIX - 1);
      oh[1]:   k = step_t'(RADIX - 2);
      oh[0]:   k = step_t'(RADIX - 3);
      default: k = step_t'(RADIX);
    endcase
    return k;
  endfunction

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction
endpackage

// File: rtl/quad_sample_sequencer_if.sv
// Upstream triangle handshake bundle for the quad sequencer.
// Optional perf counters are enabled by defining QUAD_SEQ_PERF_CNT_EN.
interface quad_sample_sequencer_if;
  import raster_pkg::*;
  tri_t   tri_in;
  color_t color_in;
  bbox_t  bbox_in;
  logic   valid_in;
  logic   ready_out;

  modport master (
    output tri_in, color_in, bbox_in, valid_in,
    input  ready_out
  );
  modport slave (
    input  tri_in, color_in, bbox_in, valid_in,
    output ready_out
  );
endinterface

// File: rtl/quad_sample_sequencer_quad_gen.sv
// Combinational 2x2 quad positions, in-box valids and walk-step flags.
// Optional perf counters are enabled by defining QUAD_SEQ_PERF_CNT_EN.
module quad_gen
  import raster_pkg::*;
(
  input  sword_t      cx_i,
  input  sword_t      cy_i,
  input  ext_t        s_i,
  input  sword_t      urx_i,
  input  sword_t      ury_i,
  output quad_t       pos_o,
  output logic [3:0]  valid_o,
  output sword_t      nx_o,
  output sword_t      ny_o,
  output logic        row_end_o,
  output logic        last_o
);
  ext_t x0, x1, x2, y0, y1, y2, ux, uy;
  logic vx0, vx1, vy0, vy1;

  // One extra bit so a step past max positive compares as beyond UR
  assign x0 = {cx_i[SIGFIG-1], cx_i};
  assign y0 = {cy_i[SIGFIG-1], cy_i};
  assign ux = {urx_i[SIGFIG-1], urx_i};
  assign uy = {ury_i[SIGFIG-1], ury_i};
  assign x1 = x0 + s_i;
  assign y1 = y0 + s_i;
  assign x2 = x0 + (s_i <<< 1);
  assign y2 = y0 + (s_i <<< 1);

  assign vx0 = x0 <= ux;
  assign vx1 = x1 <= ux;
  assign vy0 = y0 <= uy;
  assign vy1 = y1 <= uy;

  assign valid_o = {vx1 & vy1, vx0 & vy1, vx1 & vy0, vx0 & vy0};

  assign pos_o[0] = {x1[SIGFIG-1:0], x0[SIGFIG-1:0],
                     x1[SIGFIG-1:0], x0[SIGFIG-1:0]};
  assign pos_o[1] = {y1[SIGFIG-1:0], y1[SIGFIG-1:0],
                     y0[SIGFIG-1:0], y0[SIGFIG-1:0]};

  assign nx_o      = x2[SIGFIG-1:0];
  assign ny_o      = y2[SIGFIG-1:0];
  assign row_end_o = x2 > ux;
  assign last_o    = row_end_o && (y2 > uy);
endmodule

// File: rtl/quad_sample_sequencer.sv
// Walks a triangle bounding box in 2x2 sample quads for the jitter-hash stage.
// Optional perf counters are enabled by defining QUAD_SEQ_PERF_CNT_EN.
module quad_sample_sequencer
  import raster_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  quad_sample_sequencer_if.slave up,
  input  logic       halt_in,
  input  logic       cfg_we,
  input  logic [3:0] cfg_subSample,
  output tri_t       tri_R14S,
  output color_t     color_R14U,
  output quad_t      sample_R14S,
  output logic [3:0] validSamp_R14H,
  output logic [3:0] subSample_RnnnnU,
  output logic       cfg_err,
  output logic       busy
`ifdef QUAD_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_quads,
  output logic [31:0] perf_halts
`endif
);
  seq_state_t state_q;
  logic [3:0] cfg_q, cfg_d;
  logic       cfg_err_q;
  tri_t       tri_q;
  color_t     color_q;
  quad_t      sample_q;
  logic [3:0] vs_q;
  sword_t     urx_q, ury_q, llx_q, cx_q, cy_q;

  logic       idle, cfg_ok;
  step_t      k;
  ext_t       s;
  sword_t     mask, llx_snap, lly_snap;
  logic       degen;
  quad_t      pos;
  logic [3:0] valid;
  sword_t     nx, ny;
  logic       row_end, last;

  assign idle   = state_q == IDLE;
  assign cfg_ok = idle && cfg_we && onehot4(cfg_subSample);
  // A same-cycle config write steers the triangle being accepted
  assign cfg_d  = cfg_ok ? cfg_subSample : cfg_q;
  assign k      = subsample_step(cfg_d);
  assign s      = ext_t'(1) << k;
  assign mask   = ~((sword_t'(1) << k) - sword_t'(1));

  assign llx_snap = $signed(up.bbox_in[0][0]) & mask;
  assign lly_snap = $signed(up.bbox_in[0][1]) & mask;
  assign degen = ($signed(up.bbox_in[1][0]) < $signed(up.bbox_in[0][0]))
              || ($signed(up.bbox_in[1][1]) < $signed(up.bbox_in[0][1]));

  assign up.ready_out     = idle;
  assign busy             = state_q == WALK;
  assign tri_R14S         = tri_q;
  assign color_R14U       = color_q;
  assign sample_R14S      = sample_q;
  assign validSamp_R14H   = vs_q;
  assign subSample_RnnnnU = cfg_q;
  assign cfg_err          = cfg_err_q;

  quad_gen u_gen (
    .cx_i      (cx_q),
    .cy_i      (cy_q),
    .s_i       (s),
    .urx_i     (urx_q),
    .ury_i     (ury_q),
    .pos_o     (pos),
    .valid_o   (valid),
    .nx_o      (nx),
    .ny_o      (ny),
    .row_end_o (row_end),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cfg_q     <= 4'b1000;
      cfg_err_q <= 1'b0;
      tri_q     <= '0;
      color_q   <= '0;
      sample_q  <= '0;
      vs_q      <= '0;
      urx_q     <= '0;
      ury_q     <= '0;
      llx_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
    end else begin
      cfg_q <= cfg_d;
      if (idle && cfg_we && !onehot4(cfg_subSample))
        cfg_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          vs_q <= '0;
          if (up.valid_in) begin
            tri_q   <= up.tri_in;
            color_q <= up.color_in;
            urx_q   <= $signed(up.bbox_in[1][0]);
            ury_q   <= $signed(up.bbox_in[1][1]);
            llx_q   <= llx_snap;
            cx_q    <= llx_snap;
            cy_q    <= lly_snap;
            if (!degen)
              state_q <= WALK;
          end
        end
        WALK: begin
          if (halt_in) begin
            vs_q <= '0;
          end else begin
            sample_q <= pos;
            vs_q     <= valid;
            if (last) begin
              state_q <= IDLE;
            end else if (row_end) begin
              cx_q <= llx_q;
              cy_q <= ny;
            end else begin
              cx_q <= nx;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QUAD_SEQ_PERF_CNT_EN
  logic [31:0] perf_quads_q, perf_halts_q;

  assign perf_quads = perf_quads_q;
  assign perf_halts = perf_halts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_quads_q <= '0;
      perf_halts_q <= '0;
    end else if (state_q == WALK) begin
      if (halt_in) begin
        if (perf_halts_q != '1)
          perf_halts_q <= perf_halts_q + 32'd1;
      end else if ((|valid) && (perf_quads_q != '1)) begin
        perf_quads_q <= perf_quads_q + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_quad_sample_sequencer.sv
// Directed self-checking bench for quad_sample_sequencer.
// Perf counter checks are compiled in when QUAD_SEQ_PERF_CNT_EN is defined.
module tb_quad_sample_sequencer;
  import raster_pkg::*;

  logic       clk;
  logic       rst;
  logic       halt_in;
  logic       cfg_we;
  logic [3:0] cfg_subSample;
  tri_t       tri_o;
  color_t     color_o;
  quad_t      samp;
  logic [3:0] vs;
  logic [3:0] sub;
  logic       cfg_err;
  logic       busy;
`ifdef QUAD_SEQ_PERF_CNT_EN
  logic [31:0] perf_quads, perf_halts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  quad_sample_sequencer_if bus();

  quad_sample_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .up               (bus),
    .halt_in          (halt_in),
    .cfg_we           (cfg_we),
    .cfg_subSample    (cfg_subSample),
    .tri_R14S         (tri_o),
    .color_R14U       (color_o),
    .sample_R14S      (samp),
    .validSamp_R14H   (vs),
    .subSample_RnnnnU (sub),
    .cfg_err          (cfg_err),
    .busy             (busy)
`ifdef QUAD_SEQ_PERF_CNT_EN
    ,
    .perf_quads       (perf_quads),
    .perf_halts       (perf_halts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic quad_t mkq(input int x0, input int x1,
                                input int y0, input int y1);
    quad_t q;
    q[0] = {word_t'(x1), word_t'(x0), word_t'(x1), word_t'(x0)};
    q[1] = {word_t'(y1), word_t'(y1), word_t'(y0), word_t'(y0)};
    return q;
  endfunction

  task automatic handshake(input int lx, input int ly,
                           input int ux, input int uy);
    bus.bbox_in[0][0] = word_t'(lx);
    bus.bbox_in[0][1] = word_t'(ly);
    bus.bbox_in[1][0] = word_t'(ux);
    bus.bbox_in[1][1] = word_t'(uy);
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_out);
    end
    n_checks++;
    if (sub !== 4'b1000) begin
      n_fail++; $display("FAIL reset_sub: got %b want 1000", sub);
    end
    n_checks++;
    if (vs !== 4'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: vs=%b busy=%b err=%b want 0/0/0",
               vs, busy, cfg_err);
    end
    n_checks++;
    if (samp !== '0 || tri_o !== '0 || color_o !== '0) begin
      n_fail++; $display("FAIL reset_data: samp=%h want 0", samp);
    end
  endtask

  task automatic test_single_quad;
    quad_t e;
    handshake(0, 0, 1024, 1024);
    n_checks++;
    if (busy !== 1'b1 || bus.ready_out !== 1'b0 || vs !== 4'b0) begin
      n_fail++;
      $display("FAIL single_accept: busy=%b rdy=%b vs=%b want 1/0/0",
               busy, bus.ready_out, vs);
    end
    @(posedge clk); #1;
    e = mkq(0, 1024, 0, 1024);
    n_checks++;
    if (samp !== e) begin
      n_fail++; $display("FAIL single_pos: got %h want %h", samp, e);
    end
    n_checks++;
    if (vs !== 4'b1111) begin
      n_fail++; $display("FAIL single_valid: got %b want 1111", vs);
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b want 1", bus.ready_out);
    end
    n_checks++;
    if (tri_o !== bus.tri_in || color_o !== bus.color_in) begin
      n_fail++; $display("FAIL single_tri: got %h want %h", tri_o, bus.tri_in);
    end
    @(posedge clk); #1;
    n_checks++;
    if (vs !== 4'b0) begin
      n_fail++; $display("FAIL single_idle_vs: got %b want 0000", vs);
    end
  endtask

  task automatic test_two_quads;
    quad_t e;
    handshake(0, 0, 2048, 1024);
    @(posedge clk); #1;
    e = mkq(0, 1024, 0, 1024);
    n_checks++;
    if (samp !== e || vs !== 4'b1111) begin
      n_fail++; $display("FAIL two_q1: got %h/%b want %h/1111", samp, vs, e);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL two_busy: got %b want 1", busy);
    end
    @(posedge clk); #1;
    e = mkq(2048, 3072, 0, 1024);
    n_checks++;
    if (samp !== e) begin
      n_fail++; $display("FAIL two_q2_pos: got %h want %h", samp, e);
    end
    n_checks++;
    if (vs !== 4'b0101) begin
      n_fail++; $display("FAIL two_q2_valid: got %b want 0101", vs);
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL two_ready: got %b want 1", bus.ready_out);
    end
  endtask

  task automatic test_halt;
    quad_t e;
`ifdef QUAD_SEQ_PERF_CNT_EN
    logic [31:0] ph0, pq0;
    ph0 = perf_halts;
    pq0 = perf_quads;
`endif
    handshake(0, 0, 2048, 1024);
    @(posedge clk); #1;
    n_checks++;
    if (vs !== 4'b1111) begin
      n_fail++; $display("FAIL halt_q1: got %b want 1111", vs);
    end
    halt_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (vs !== 4'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold%0d: vs=%b busy=%b want 0000/1", i, vs, busy);
      end
    end
    halt_in = 1'b0;
    @(posedge clk); #1;
    e = mkq(2048, 3072, 0, 1024);
    n_checks++;
    if (samp !== e || vs !== 4'b0101) begin
      n_fail++;
      $display("FAIL halt_q2: got %h/%b want %h/0101", samp, vs, e);
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL halt_ready: got %b want 1", bus.ready_out);
    end
`ifdef QUAD_SEQ_PERF_CNT_EN
    n_checks++;
    if (perf_halts - ph0 !== 32'd3 || perf_quads - pq0 !== 32'd2) begin
      n_fail++;
      $display("FAIL halt_perf: halts+%0d quads+%0d want 3/2",
               perf_halts - ph0, perf_quads - pq0);
    end
`endif
  endtask

  task automatic test_degenerate;
    handshake(0, 0, -1024, 0);
    n_checks++;
    if (bus.ready_out !== 1'b1 || busy !== 1'b0 || vs !== 4'b0) begin
      n_fail++;
      $display("FAIL degen_accept: rdy=%b busy=%b vs=%b want 1/0/0000",
               bus.ready_out, busy, vs);
    end
    @(posedge clk); #1;
    n_checks++;
    if (vs !== 4'b0 || bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL degen_next: vs=%b rdy=%b want 0000/1", vs, bus.ready_out);
    end
  endtask

  task automatic test_snap;
    quad_t e;
    handshake(1500, 1100, 2048, 2048);
    @(posedge clk); #1;
    e = mkq(1024, 2048, 1024, 2048);
    n_checks++;
    if (samp !== e || vs !== 4'b1111) begin
      n_fail++;
      $display("FAIL snap_q: got %h/%b want %h/1111", samp, vs, e);
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL snap_ready: got %b want 1", bus.ready_out);
    end
  endtask

  task automatic test_overflow;
    handshake(8387584, 0, 8388607, 0);
    @(posedge clk); #1;
    n_checks++;
    if (samp[0][0] !== word_t'(8387584)) begin
      n_fail++; $display("FAIL ovf_x0: got %h want 7ffc00", samp[0][0]);
    end
    n_checks++;
    if (vs !== 4'b0001) begin
      n_fail++; $display("FAIL ovf_valid: got %b want 0001", vs);
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL ovf_ready: got %b want 1", bus.ready_out);
    end
  endtask

  task automatic test_cfg;
    quad_t e;
    cfg_we = 1'b1;
    cfg_subSample = 4'b0011;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || sub !== 4'b1000) begin
      n_fail++;
      $display("FAIL cfg_bad: err=%b sub=%b want 1/1000", cfg_err, sub);
    end
    cfg_we = 1'b1;
    cfg_subSample = 4'b0100;
    handshake(100, 0, 512, 512);
    cfg_we = 1'b0;
    n_checks++;
    if (sub !== 4'b0100) begin
      n_fail++; $display("FAIL cfg_same_cycle: got %b want 0100", sub);
    end
    @(posedge clk); #1;
    e = mkq(0, 512, 0, 512);
    n_checks++;
    if (samp !== e || vs !== 4'b1111 || bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_s512: got %h/%b/%b want %h/1111/1",
               samp, vs, bus.ready_out, e);
    end
    handshake(0, 0, 2048, 0);
    cfg_we = 1'b1;
    cfg_subSample = 4'b0001;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_checks++;
    if (sub !== 4'b0100 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_walk_ignored: sub=%b busy=%b want 0100/1", sub, busy);
    end
    for (int i = 0; i < 20 && bus.ready_out !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++; $display("FAIL cfg_walk_done: ready=%b want 1", bus.ready_out);
    end
  endtask

  task automatic test_reset_mid_walk;
    n_checks++;
    if (sub !== 4'b0100) begin
      n_fail++; $display("FAIL rmw_pre_sub: got %b want 0100", sub);
    end
    handshake(0, 0, 8192, 8192);
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || vs !== 4'b1111) begin
      n_fail++;
      $display("FAIL rmw_walking: busy=%b vs=%b want 1/1111", busy, vs);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rmw_state: busy=%b rdy=%b want 0/1", busy, bus.ready_out);
    end
    n_checks++;
    if (vs !== 4'b0 || samp !== '0 || tri_o !== '0 || color_o !== '0) begin
      n_fail++; $display("FAIL rmw_outputs: vs=%b samp=%h want 0", vs, samp);
    end
    n_checks++;
    if (sub !== 4'b1000 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_cfg: sub=%b err=%b want 1000/0", sub, cfg_err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || vs !== 4'b0) begin
      n_fail++;
      $display("FAIL rmw_after: busy=%b vs=%b want 0/0000", busy, vs);
    end
  endtask

  initial begin
    rst = 1'b0;
    halt_in = 1'b0;
    cfg_we = 1'b0;
    cfg_subSample = 4'b1000;
    bus.valid_in = 1'b0;
    bus.bbox_in = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        bus.tri_in[v][a] = word_t'(v * 16 + a + 1);
    bus.color_in = {24'h0000ff, 24'h00ff00, 24'hff0000};
    #12;
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_quad();
    test_two_quads();
    test_halt();
    test_degenerate();
    test_snap();
    test_overflow();
    test_cfg();
    test_reset_mid_walk();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
